// File: rtl/sobel_pkg.sv
// Shared types for the sobel front end: line-buffer FSM states and tap-valid encodings.
package sobel_pkg;

  typedef enum logic [1:0] {
    LB_IDLE,
    LB_ROW0,
    LB_ROW1,
    LB_STEADY
  } line_buf_state_e;

  // Bit positions inside taps_valid_o.
  localparam int TV_MID_BIT = 0;
  localparam int TV_TOP_BIT = 1;

  localparam logic [1:0] TV_NONE = 2'b00;
  localparam logic [1:0] TV_MID  = 2'b01;
  localparam logic [1:0] TV_ALL  = 2'b11;

endpackage

// File: rtl/sync_ram_block.sv
// Simple dual-port synchronous RAM: port A read-only, port B read/write with read-before-write.
module sync_ram_block #(
  parameter int WIDTH_P = 8,
  parameter int DEPTH_P = 16
) (
  input  logic                       clk_i,
  input  logic                       a_en_i,
  input  logic [$clog2(DEPTH_P)-1:0] a_addr_i,
  output logic [WIDTH_P-1:0]         a_rdata_o,
  input  logic                       b_en_i,
  input  logic                       b_we_i,
  input  logic [$clog2(DEPTH_P)-1:0] b_addr_i,
  input  logic [WIDTH_P-1:0]         b_wdata_i,
  output logic [WIDTH_P-1:0]         b_rdata_o
);

  logic [WIDTH_P-1:0] mem_q [DEPTH_P];
  logic [WIDTH_P-1:0] a_rdata_q, b_rdata_q;

  // Read data holds its value whenever the port is not enabled.
  always_ff @(posedge clk_i) begin
    if (a_en_i) a_rdata_q <= mem_q[a_addr_i];
    if (b_en_i) begin
      b_rdata_q <= mem_q[b_addr_i];
      if (b_we_i) mem_q[b_addr_i] <= b_wdata_i;
    end
  end

  assign a_rdata_o = a_rdata_q;
  assign b_rdata_o = b_rdata_q;

endmodule

// File: rtl/line_buffer_ctrl.sv
// Two-line buffer producing a 3-row column (r-2, r-1, r) per accepted pixel, one cycle after accept.
module line_buffer_ctrl
  import sobel_pkg::*;
#(
  parameter int WIDTH_P   = 8,
  parameter int LINE_W_P  = 640,
  parameter int FRAME_H_P = 480
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  input  logic [WIDTH_P-1:0]            pixel_i,
  input  logic                          sof_i,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [WIDTH_P-1:0]            tap_top_o,
  output logic [WIDTH_P-1:0]            tap_mid_o,
  output logic [WIDTH_P-1:0]            tap_bot_o,
  output logic [$clog2(LINE_W_P)-1:0]   col_o,
  output logic [$clog2(FRAME_H_P)-1:0]  row_o,
  output logic [1:0]                    taps_valid_o,
  output logic                          sol_o,
  output logic                          eol_o,
  output logic                          sof_o,
  output logic                          eof_o,
  output logic                          drop_o
);

  localparam int COL_W  = $clog2(LINE_W_P);
  localparam int ROW_W  = $clog2(FRAME_H_P);
  localparam int ADDR_W = $clog2(2 * LINE_W_P);
  localparam logic [COL_W-1:0]  COL_LAST   = COL_W'(LINE_W_P - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST   = ROW_W'(FRAME_H_P - 1);
  localparam logic [ADDR_W-1:0] BANK1_BASE = ADDR_W'(LINE_W_P);

  line_buf_state_e state_q, state_d, cur_state;
  logic [COL_W-1:0]   col_q, col_d, out_col_q, out_col_d, pix_col;
  logic [ROW_W-1:0]   row_q, row_d, out_row_q, out_row_d, pix_row;
  logic [WIDTH_P-1:0] bot_q, bot_d;
  logic [1:0]         tv_q, tv_d;
  logic valid_q, valid_d, drop_q, drop_d;
  logic sol_q, sol_d, eol_q, eol_d, sof_q, sof_d, eof_q, eof_d;
  logic accept, fwd, ram_en;
  logic [ADDR_W-1:0]  a_addr, b_addr;
  logic [WIDTH_P-1:0] a_rdata, b_rdata;

  always_comb begin
    ready_o   = !valid_q | ready_i;
    accept    = valid_i & ready_o;
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    valid_d   = valid_q & !ready_i;
    drop_d    = 1'b0;
    bot_d     = bot_q;
    out_col_d = out_col_q;
    out_row_d = out_row_q;
    tv_d      = tv_q;
    sol_d     = sol_q;
    eol_d     = eol_q;
    sof_d     = sof_q;
    eof_d     = eof_q;
    fwd       = 1'b0;
    pix_col   = col_q;
    pix_row   = row_q;
    cur_state = state_q;

    // sof_i always restarts the frame; outside a frame anything else is dropped.
    if (accept) begin
      if (sof_i) begin
        fwd       = 1'b1;
        pix_col   = '0;
        pix_row   = '0;
        cur_state = LB_ROW0;
      end else if (state_q == LB_IDLE) begin
        drop_d = 1'b1;
      end else begin
        fwd = 1'b1;
      end
    end

    if (fwd) begin
      valid_d   = 1'b1;
      bot_d     = pixel_i;
      out_col_d = pix_col;
      out_row_d = pix_row;
      sol_d     = (pix_col == '0);
      eol_d     = (pix_col == COL_LAST);
      sof_d     = (pix_row == '0) && (pix_col == '0);
      eof_d     = (pix_row == ROW_LAST) && (pix_col == COL_LAST);
      case (cur_state)
        LB_ROW1:   tv_d = TV_MID;
        LB_STEADY: tv_d = TV_ALL;
        default:   tv_d = TV_NONE;
      endcase
      state_d = cur_state;
      if (pix_col == COL_LAST) begin
        col_d = '0;
        row_d = pix_row + 1'b1;
        case (cur_state)
          LB_ROW0: state_d = LB_ROW1;
          LB_ROW1: state_d = LB_STEADY;
          LB_STEADY: begin
            if (pix_row == ROW_LAST) begin
              state_d = LB_IDLE;
              row_d   = '0;
            end
          end
          default: state_d = LB_IDLE;
        endcase
      end else begin
        col_d = pix_col + 1'b1;
        row_d = pix_row;
      end
    end
  end

  // Port B hits the bank being written (row r-2), port A the other bank (row r-1).
  always_comb begin
    ram_en = fwd & rstn_i;
    a_addr = (pix_row[0] ? '0 : BANK1_BASE) + ADDR_W'(pix_col);
    b_addr = (pix_row[0] ? BANK1_BASE : '0) + ADDR_W'(pix_col);
  end

  sync_ram_block #(
    .WIDTH_P (WIDTH_P),
    .DEPTH_P (2 * LINE_W_P)
  ) u_ram (
    .clk_i     (clk_i),
    .a_en_i    (ram_en),
    .a_addr_i  (a_addr),
    .a_rdata_o (a_rdata),
    .b_en_i    (ram_en),
    .b_we_i    (ram_en),
    .b_addr_i  (b_addr),
    .b_wdata_i (pixel_i),
    .b_rdata_o (b_rdata)
  );

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q   <= LB_IDLE;
      col_q     <= '0;
      row_q     <= '0;
      valid_q   <= 1'b0;
      drop_q    <= 1'b0;
      bot_q     <= '0;
      out_col_q <= '0;
      out_row_q <= '0;
      tv_q      <= TV_NONE;
      sol_q     <= 1'b0;
      eol_q     <= 1'b0;
      sof_q     <= 1'b0;
      eof_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      valid_q   <= valid_d;
      drop_q    <= drop_d;
      bot_q     <= bot_d;
      out_col_q <= out_col_d;
      out_row_q <= out_row_d;
      tv_q      <= tv_d;
      sol_q     <= sol_d;
      eol_q     <= eol_d;
      sof_q     <= sof_d;
      eof_q     <= eof_d;
    end
  end

  // Masking keeps stale RAM contents (e.g. after reset) off the taps until refilled.
  assign tap_top_o    = tv_q[TV_TOP_BIT] ? b_rdata : '0;
  assign tap_mid_o    = tv_q[TV_MID_BIT] ? a_rdata : '0;
  assign tap_bot_o    = bot_q;
  assign col_o        = out_col_q;
  assign row_o        = out_row_q;
  assign taps_valid_o = tv_q;
  assign valid_o      = valid_q;
  assign drop_o       = drop_q;
  assign sol_o        = sol_q;
  assign eol_o        = eol_q;
  assign sof_o        = sof_q;
  assign eof_o        = eof_q;

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Self-checking bench for line_buffer_ctrl on a 4x4 frame against an image-array reference model.
module tb_line_buffer_ctrl;

  localparam int W  = 8;
  localparam int LW = 4;
  localparam int FH = 4;

  logic clk_i = 1'b0, rstn_i = 1'b0, valid_i = 1'b0, sof_i = 1'b0, ready_i = 1'b0;
  logic [W-1:0] pixel_i = '0;
  logic ready_o, valid_o, sol_o, eol_o, sof_o, eof_o, drop_o;
  logic [W-1:0] tap_top_o, tap_mid_o, tap_bot_o;
  logic [1:0] col_o, row_o, taps_valid_o;

  always #5 clk_i = ~clk_i;

  line_buffer_ctrl #(.WIDTH_P(W), .LINE_W_P(LW), .FRAME_H_P(FH)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .valid_i(valid_i), .ready_o(ready_o),
    .pixel_i(pixel_i), .sof_i(sof_i), .valid_o(valid_o), .ready_i(ready_i),
    .tap_top_o(tap_top_o), .tap_mid_o(tap_mid_o), .tap_bot_o(tap_bot_o),
    .col_o(col_o), .row_o(row_o), .taps_valid_o(taps_valid_o),
    .sol_o(sol_o), .eol_o(eol_o), .sof_o(sof_o), .eof_o(eof_o), .drop_o(drop_o)
  );

  wire [33:0] obs = {tap_top_o, tap_mid_o, tap_bot_o, col_o, row_o, taps_valid_o,
                     sol_o, eol_o, sof_o, eof_o};

  int checks = 0;
  int passed = 0;

  // Reference model: pixels of the current frame by position, plus the expected output word.
  logic [W-1:0] img [FH][LW];
  bit   in_frame;
  int   mr, mc;
  bit   ev, ed, acc;
  logic [33:0] exp_d;

  task automatic apply_reset(input int n);
    rstn_i = 1'b0; valid_i = 1'b0; sof_i = 1'b0; ready_i = 1'b0;
    ev = 0; ed = 0; exp_d = '0; in_frame = 0; mr = 0; mc = 0;
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic cyc(input bit v, input bit s, input logic [W-1:0] p, input bit rdy);
    int r, c;
    logic [W-1:0] top, mid;
    logic [1:0] tv;
    rstn_i = 1'b1; valid_i = v; sof_i = s; pixel_i = p; ready_i = rdy;
    acc = v && (!ev || rdy);
    ed = 0;
    if (acc && (s || in_frame)) begin
      if (s) begin r = 0; c = 0; in_frame = 1; end
      else begin r = mr; c = mc; end
      img[r][c] = p;
      top = (r >= 2) ? img[r-2][c] : '0;
      mid = (r >= 1) ? img[r-1][c] : '0;
      tv  = (r >= 2) ? 2'b11 : (r == 1) ? 2'b01 : 2'b00;
      exp_d = {top, mid, p, 2'(c), 2'(r), tv, (c == 0), (c == LW-1),
               (r == 0 && c == 0), (r == FH-1 && c == LW-1)};
      ev = 1;
      c++;
      if (c == LW) begin c = 0; r++; end
      if (r == FH) begin r = 0; in_frame = 0; end
      mr = r; mc = c;
    end else if (acc) begin
      ev = 0; ed = 1;
    end else if (rdy) begin
      ev = 0;
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset;
    apply_reset(2);
    checks++;
    if ({valid_o, drop_o, ready_o, obs} !== {3'b001, 34'h0})
      $display("FAIL reset got v/d/r=%b data=%h exp 001/0", {valid_o, drop_o, ready_o}, obs);
    else passed++;
  endtask

  task automatic test_full_frame;
    for (int i = 0; i <= LW*FH; i++) begin
      if (i < LW*FH) cyc(1, i == 0, 8'(16*(i/LW) + i%LW), 1);
      else cyc(0, 0, '0, 1);
      checks++;
      if ({valid_o, drop_o, ready_o} !== {ev, ed, (!ev || ready_i)})
        $display("FAIL full_ctl i=%0d got %b exp %b", i, {valid_o, drop_o, ready_o}, {ev, ed, (!ev || ready_i)});
      else passed++;
      if (ev) begin
        checks++;
        if (obs !== exp_d) $display("FAIL full_data i=%0d got %h exp %h", i, obs, exp_d);
        else passed++;
      end
      if (i == 2*LW + 3) begin
        checks++;
        if ({tap_top_o, tap_mid_o, tap_bot_o, taps_valid_o, eol_o} !== {8'h03, 8'h13, 8'h23, 2'b11, 1'b1})
          $display("FAIL full_23 got %h/%h/%h tv=%b eol=%b exp 03/13/23 tv=11 eol=1",
                   tap_top_o, tap_mid_o, tap_bot_o, taps_valid_o, eol_o);
        else passed++;
      end
    end
  endtask

  task automatic test_drop;
    for (int i = 0; i < 4; i++) begin
      if (i < 3) cyc(1, 0, 8'(8'hA0 + i), 1);
      else cyc(0, 0, '0, 1);
      checks++;
      if ({valid_o, drop_o, ready_o} !== {ev, ed, (!ev || ready_i)})
        $display("FAIL drop_ctl i=%0d got %b exp %b", i, {valid_o, drop_o, ready_o}, {ev, ed, (!ev || ready_i)});
      else passed++;
      if (i < 3) begin
        checks++;
        if ({valid_o, drop_o} !== 2'b01) $display("FAIL drop_pulse i=%0d got v/d=%b exp 01", i, {valid_o, drop_o});
        else passed++;
      end
    end
  endtask

  task automatic test_stall;
    int k;
    bit rdy;
    k = 0;
    for (int i = 0; i < 40 && k < LW*FH; i++) begin
      rdy = !(i >= 7 && i < 10);
      cyc(1, k == 0, 8'(16*(k/LW) + k%LW), rdy);
      if (acc) k++;
      checks++;
      if ({valid_o, drop_o, ready_o} !== {ev, ed, (!ev || ready_i)})
        $display("FAIL stall_ctl i=%0d got %b exp %b", i, {valid_o, drop_o, ready_o}, {ev, ed, (!ev || ready_i)});
      else passed++;
      if (ev) begin
        checks++;
        if (obs !== exp_d) $display("FAIL stall_data i=%0d got %h exp %h", i, obs, exp_d);
        else passed++;
      end
      if (!rdy) begin
        checks++;
        if ({ready_o, valid_o, tap_top_o, tap_mid_o, tap_bot_o} !== {1'b0, 1'b1, 8'h00, 8'h02, 8'h12})
          $display("FAIL stall_hold i=%0d got r=%b v=%b %h/%h/%h exp r=0 v=1 00/02/12",
                   i, ready_o, valid_o, tap_top_o, tap_mid_o, tap_bot_o);
        else passed++;
      end
    end
    checks++;
    if (k != LW*FH) $display("FAIL stall_count got %0d exp %0d", k, LW*FH);
    else passed++;
    cyc(0, 0, '0, 1);
  endtask

  task automatic test_sof_restart;
    for (int i = 0; i < 10 + LW*FH; i++) begin
      if (i < 10) cyc(1, i == 0 || i == 9, 8'(16*(i/LW) + i%LW), 1);
      else if (i < 9 + LW*FH) cyc(1, 0, 8'(8'h80 + 16*((i-9)/LW) + (i-9)%LW), 1);
      else cyc(0, 0, '0, 1);
      checks++;
      if ({valid_o, drop_o, ready_o} !== {ev, ed, (!ev || ready_i)})
        $display("FAIL sof_ctl i=%0d got %b exp %b", i, {valid_o, drop_o, ready_o}, {ev, ed, (!ev || ready_i)});
      else passed++;
      if (ev) begin
        checks++;
        if (obs !== exp_d) $display("FAIL sof_data i=%0d got %h exp %h", i, obs, exp_d);
        else passed++;
      end
      if (i == 9) begin
        checks++;
        if ({row_o, col_o, sof_o, taps_valid_o, tap_bot_o} !== {2'd0, 2'd0, 1'b1, 2'b00, 8'h21})
          $display("FAIL sof_restart got row=%0d col=%0d sof=%b tv=%b bot=%h exp 0/0/1/00/21",
                   row_o, col_o, sof_o, taps_valid_o, tap_bot_o);
        else passed++;
      end
    end
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 2*LW; i++) cyc(1, i == 0, 8'(8'h40 + i), 1);
    checks++;
    if ({valid_o, row_o, col_o} !== {1'b1, 2'd1, 2'd3})
      $display("FAIL rstmid_pre got v=%b row=%0d col=%0d exp 1/1/3", valid_o, row_o, col_o);
    else passed++;
    apply_reset(1);
    checks++;
    if ({valid_o, taps_valid_o, tap_top_o, tap_mid_o, tap_bot_o} !== 27'h0)
      $display("FAIL rstmid_clear got v=%b tv=%b %h/%h/%h exp all 0",
               valid_o, taps_valid_o, tap_top_o, tap_mid_o, tap_bot_o);
    else passed++;
    cyc(1, 0, 8'h55, 1);
    checks++;
    if ({valid_o, drop_o} !== 2'b01) $display("FAIL rstmid_idle got v/d=%b exp 01", {valid_o, drop_o});
    else passed++;
    for (int j = 0; j < 2*LW; j++) begin
      cyc(1, j == 0, 8'(8'hC0 + j), 1);
      checks++;
      if (obs !== exp_d) $display("FAIL rstmid_data j=%0d got %h exp %h", j, obs, exp_d);
      else passed++;
      checks++;
      if ({valid_o, taps_valid_o} !== {1'b1, (j < LW) ? 2'b00 : 2'b01})
        $display("FAIL rstmid_tv j=%0d got v=%b tv=%b", j, valid_o, taps_valid_o);
      else passed++;
    end
  endtask

  task automatic test_random;
    int k;
    k = 0;
    for (int i = 0; i < 2000 && k < 3*LW*FH; i++) begin
      cyc($urandom_range(0, 3) != 0, k % (LW*FH) == 0, 8'($urandom), $urandom_range(0, 3) != 0);
      if (acc) k++;
      checks++;
      if ({valid_o, drop_o, ready_o} !== {ev, ed, (!ev || ready_i)})
        $display("FAIL rand_ctl i=%0d got %b exp %b", i, {valid_o, drop_o, ready_o}, {ev, ed, (!ev || ready_i)});
      else passed++;
      if (ev) begin
        checks++;
        if (obs !== exp_d) $display("FAIL rand_data i=%0d got %h exp %h", i, obs, exp_d);
        else passed++;
      end
    end
    checks++;
    if (k != 3*LW*FH) $display("FAIL rand_budget got %0d pixels exp %0d", k, 3*LW*FH);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_drop();
    test_stall();
    test_sof_restart();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
